// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller.
// State encoding and the hard-wired zero register number.
package hazard_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      HOLD1 = 1'b1
   } state_e;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM status in, pipeline
// enables and performance counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
);
   logic             ext_stall;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_branch;
   logic             id_branch_taken;
   logic             id_jump;
   logic             id_jr;
   logic             ex_mem_read;
   logic             ex_reg_write;
   logic [REG_W-1:0] ex_wreg;
   logic             mem_mem_read;
   logic [REG_W-1:0] mem_wreg;
   logic             pc_write;
   logic             ifid_write;
   logic             if_flush;
   logic             idex_bubble;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ext_stall, id_rs, id_rt, id_use_rs, id_use_rt,
      output id_branch, id_branch_taken, id_jump, id_jr,
      output ex_mem_read, ex_reg_write, ex_wreg,
      output mem_mem_read, mem_wreg,
      input  pc_write, ifid_write, if_flush, idex_bubble,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  ext_stall, id_rs, id_rt, id_use_rs, id_use_rt,
      input  id_branch, id_branch_taken, id_jump, id_jr,
      input  ex_mem_read, ex_reg_write, ex_wreg,
      input  mem_mem_read, mem_wreg,
      output pc_write, ifid_write, if_flush, idex_bubble,
      output stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Register dependency comparator: hit when a read operand
// matches a nonzero destination register.
module hazard_cmp
   import hazard_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] r_i,
   input  logic [W-1:0] w_i,
   input  logic         en_i,
   output logic         hit_o
);

   assign hit_o = en_i & (w_i != W'(REG_ZERO)) & (r_i == w_i);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage stall/flush controller with a two-cycle hold for
// branch-on-load and saturating stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic rs_ctl, ctl;
   logic ld_rs, ld_rt;
   logic ex_rs, ex_rt;
   logic mem_rs, mem_rt;
   logic load_use, ctl_ex, ctl_mem;
   logic stall, redirect;
   logic pc_we, ifid_we, flush, bubble;

   // jr reads rs even if the decoder leaves use_rs low
   assign ctl    = bus.id_branch | bus.id_jr;
   assign rs_ctl = bus.id_use_rs | bus.id_jr;

   hazard_cmp #(.W(REG_W)) u_ld_rs (
      .r_i(bus.id_rs), .w_i(bus.ex_wreg),
      .en_i(bus.id_use_rs), .hit_o(ld_rs)
   );
   hazard_cmp #(.W(REG_W)) u_ld_rt (
      .r_i(bus.id_rt), .w_i(bus.ex_wreg),
      .en_i(bus.id_use_rt), .hit_o(ld_rt)
   );
   hazard_cmp #(.W(REG_W)) u_ex_rs (
      .r_i(bus.id_rs), .w_i(bus.ex_wreg),
      .en_i(rs_ctl), .hit_o(ex_rs)
   );
   hazard_cmp #(.W(REG_W)) u_ex_rt (
      .r_i(bus.id_rt), .w_i(bus.ex_wreg),
      .en_i(bus.id_use_rt), .hit_o(ex_rt)
   );
   hazard_cmp #(.W(REG_W)) u_mem_rs (
      .r_i(bus.id_rs), .w_i(bus.mem_wreg),
      .en_i(rs_ctl), .hit_o(mem_rs)
   );
   hazard_cmp #(.W(REG_W)) u_mem_rt (
      .r_i(bus.id_rt), .w_i(bus.mem_wreg),
      .en_i(bus.id_use_rt), .hit_o(mem_rt)
   );

   assign load_use = bus.ex_mem_read & (ld_rs | ld_rt);
   assign ctl_ex   = ctl & bus.ex_reg_write & (ex_rs | ex_rt);
   assign ctl_mem  = ctl & bus.mem_mem_read & (mem_rs | mem_rt);

   assign stall = bus.ext_stall | load_use | ctl_ex
                | ctl_mem | (state_q == HOLD1);
   assign redirect = bus.id_jump | bus.id_jr
                   | (bus.id_branch & bus.id_branch_taken);

   // Pipeline enables; ext_stall freezes ID/EX instead of bubbling
   always_comb begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      flush   = 1'b0;
      bubble  = 1'b0;
      if (rst) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         bubble  = 1'b1;
      end else if (stall) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         bubble  = ~bus.ext_stall;
      end else if (redirect) begin
         ifid_we = 1'b0;
         flush   = 1'b1;
      end
   end

   // Next state and saturating counter increments
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         RUN:   if (ctl_ex & bus.ex_mem_read) state_d = HOLD1;
         HOLD1: if (!bus.ext_stall) state_d = RUN;
         default: state_d = RUN;
      endcase
      if (!pc_we && stall_cnt_q != CNT_MAX)
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != CNT_MAX)
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   // State and counter registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_write     = pc_we;
   assign bus.ifid_write   = ifid_we;
   assign bus.if_flush     = flush;
   assign bus.idex_bubble  = bubble;
   assign bus.stall_cycles = stall_cnt_q;
   assign bus.flush_count  = flush_cnt_q;

endmodule
